// File: rtl/timer_mc_pkg.sv
// rtl/timer_mc_pkg.sv - shared defaults, compare reset value and mode encodings for the timer_mc family
package timer_mc_pkg;

   localparam int N_CH_DEF  = 4;
   localparam int CNT_W_DEF = 64;
`ifdef TIMER_MC_PRESCALER_EN
   localparam int PRESC_W_DEF = 16;
`endif

   // Compare registers reset to all-ones; this bit is replicated across the counter width.
   localparam logic CMP_RST = 1'b1;

   typedef enum logic {
      MODE_FREE     = 1'b0,
      MODE_PERIODIC = 1'b1
   } mode_e;

endpackage

// File: rtl/timer_mc_chan.sv
// rtl/timer_mc_chan.sv - one timer channel: counter, compare, snapshot, wrap flag and pending flag
module timer_mc_chan
   import timer_mc_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
)
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             tick,
   input  logic             sample,
   input  logic             clear,
   input  logic             periodic,
   input  logic             cmp_wr,
   input  logic [CNT_W-1:0] cmp_data,
   input  logic             irq_ack,
   output logic [CNT_W-1:0] value,
   output logic             match,
   output logic             ovf,
   output logic             irq_pend
);

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cmp;
   logic             advance;
   logic             hit;
   logic             reload;
   logic             wrap;

   // Decode this edge's counter action; clear suppresses counting and match alike.
   always_comb begin
      advance = enable & tick & ~clear;
      hit     = advance & (cnt == cmp);
      reload  = hit & (periodic == MODE_PERIODIC);
      wrap    = advance & ~reload & (periodic == MODE_FREE) & (cnt == {CNT_W{1'b1}});
   end

   // Counter, compare, snapshot and flags; snapshot takes the count from before this edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt      <= '0;
         cmp      <= {CNT_W{CMP_RST}};
         value    <= '0;
         match    <= 1'b0;
         ovf      <= 1'b0;
         irq_pend <= 1'b0;
      end else begin
         if (clear || reload) begin
            cnt <= '0;
         end else if (advance) begin
            cnt <= cnt + CNT_W'(1);
         end
         if (cmp_wr) begin
            cmp <= cmp_data;
         end
         if (sample) begin
            value <= cnt;
         end
         match <= hit;
         if (clear) begin
            ovf <= 1'b0;
         end else if (wrap) begin
            ovf <= 1'b1;
         end
         irq_pend <= hit | (irq_pend & ~irq_ack);
      end
   end

endmodule

// File: rtl/timer_mc_core.sv
// rtl/timer_mc_core.sv - multi-channel timer top: prescaler (TIMER_MC_PRESCALER_EN), cmp_wr decode, irq OR
module timer_mc_core
   import timer_mc_pkg::*;
#(
`ifdef TIMER_MC_PRESCALER_EN
   parameter int PRESC_W = PRESC_W_DEF,
`endif
   parameter int N_CH  = N_CH_DEF,
   parameter int CNT_W = CNT_W_DEF,
   parameter int SEL_W = 2
)
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [N_CH-1:0]       enable,
   input  logic [N_CH-1:0]       sample,
   input  logic [N_CH-1:0]       clear,
   input  logic [N_CH-1:0]       periodic,
   input  logic                  cmp_wr,
   input  logic [SEL_W-1:0]      cmp_sel,
   input  logic [CNT_W-1:0]      cmp_data,
   input  logic [N_CH-1:0]       irq_ack,
`ifdef TIMER_MC_PRESCALER_EN
   input  logic [PRESC_W-1:0]    presc_div,
`endif
   output logic [N_CH*CNT_W-1:0] value,
   output logic [N_CH-1:0]       match,
   output logic [N_CH-1:0]       ovf,
   output logic [N_CH-1:0]       irq_pend,
   output logic                  irq
);

   logic tick;

`ifdef TIMER_MC_PRESCALER_EN
   logic [PRESC_W-1:0] presc_cnt;

   // Shared down-counter: ticks at zero and reloads the current divisor; frozen while all channels are idle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_cnt <= '0;
      end else if (|enable) begin
         if (presc_cnt == '0) begin
            presc_cnt <= presc_div;
         end else begin
            presc_cnt <= presc_cnt - PRESC_W'(1);
         end
      end
   end

   assign tick = (presc_cnt == '0);
`else
   assign tick = 1'b1;
`endif

   // Per-channel instances; a select outside 0..N_CH-1 decodes to no channel.
   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      timer_mc_chan #(.CNT_W(CNT_W)) u_chan (
         .clk      (clk),
         .rst_n    (rst_n),
         .enable   (enable[c]),
         .tick     (tick),
         .sample   (sample[c]),
         .clear    (clear[c]),
         .periodic (periodic[c]),
         .cmp_wr   (cmp_wr && (cmp_sel == SEL_W'(c))),
         .cmp_data (cmp_data),
         .irq_ack  (irq_ack[c]),
         .value    (value[c*CNT_W +: CNT_W]),
         .match    (match[c]),
         .ovf      (ovf[c]),
         .irq_pend (irq_pend[c])
      );
   end

   // Interrupt line follows the pending flags one cycle later.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         irq <= 1'b0;
      end else begin
         irq <= |irq_pend;
      end
   end

endmodule

// File: tb/tb_timer_mc_core.sv
// tb/tb_timer_mc_core.sv - self-checking bench for timer_mc_core
module tb_timer_mc_core;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  en_a = '0, smp_a = '0, clr_a = '0, per_a = '0, ack_a = '0;
   logic        wr_a = 1'b0;
   logic [1:0]  sel_a = '0;
   logic [15:0] data_a = '0;
   logic [15:0] presc_div = '0;
   logic [47:0] val_a;
   logic [2:0]  match_a, ovf_a, pend_a;
   logic        irq_a;

   logic [3:0]  en_b = '0, smp_b = '0, clr_b = '0, per_b = '0, ack_b = '0;
   logic        wr_b = 1'b0;
   logic [1:0]  sel_b = '0;
   logic [7:0]  data_b = '0;
   logic [15:0] presc_div_b = '0;
   logic [31:0] val_b;
   logic [3:0]  match_b, ovf_b, pend_b;
   logic        irq_b;

   timer_mc_core #(.N_CH(3), .CNT_W(16), .SEL_W(2)) dut_a (
      .clk(clk), .rst_n(rst_n), .enable(en_a), .sample(smp_a), .clear(clr_a),
      .periodic(per_a), .cmp_wr(wr_a), .cmp_sel(sel_a), .cmp_data(data_a), .irq_ack(ack_a),
`ifdef TIMER_MC_PRESCALER_EN
      .presc_div(presc_div),
`endif
      .value(val_a), .match(match_a), .ovf(ovf_a), .irq_pend(pend_a), .irq(irq_a)
   );

   timer_mc_core #(.N_CH(4), .CNT_W(8), .SEL_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .enable(en_b), .sample(smp_b), .clear(clr_b),
      .periodic(per_b), .cmp_wr(wr_b), .cmp_sel(sel_b), .cmp_data(data_b), .irq_ack(ack_b),
`ifdef TIMER_MC_PRESCALER_EN
      .presc_div(presc_div_b),
`endif
      .value(val_b), .match(match_b), .ovf(ovf_b), .irq_pend(pend_b), .irq(irq_b)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic edge_step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [15:0] cmp;
      logic        per;
      int          edges;
      logic [15:0] exp_val;
      int          exp_matches;
   } vec_t;

   vec_t tbl[5];

   logic [15:0] m_cnt[3], m_cmp[3], m_val[3];
   logic [15:0] n_cnt[3], n_val[3];
   logic [2:0]  m_match, m_ovf, m_pend, n_ovf, n_pend, n_match;
   logic        m_irq;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int nm;
      logic hit;

      tbl[0] = '{16'd9,   1'b1, 25, 16'd5,  2};
      tbl[1] = '{16'd0,   1'b1, 7,  16'd0,  7};
      tbl[2] = '{16'd4,   1'b1, 5,  16'd0,  1};
      tbl[3] = '{16'd3,   1'b0, 10, 16'd10, 1};
      tbl[4] = '{16'd100, 1'b1, 50, 16'd50, 0};

      edge_step();
      edge_step();
      chk("reset_value", val_a, 48'h0);
      chk("reset_match", match_a, 3'b0);
      chk("reset_ovf", ovf_a, 3'b0);
      chk("reset_pend", pend_a, 3'b0);
      chk("reset_irq", irq_a, 1'b0);
      rst_n = 1'b1;

      // 8-bit wrap on channel 2
      en_b[2] = 1'b1;
      repeat (250) edge_step();
      chk("b_ovf_before_wrap", ovf_b[2], 1'b0);
      repeat (10) edge_step();
      en_b = '0;
      smp_b[2] = 1'b1; edge_step(); smp_b = '0;
      chk("b_value_after_wrap", val_b[23:16], 8'd4);
      chk("b_ovf_after_wrap", ovf_b[2], 1'b1);
      clr_b[2] = 1'b1; edge_step(); clr_b = '0;
      chk("b_ovf_cleared", ovf_b[2], 1'b0);
      smp_b[2] = 1'b1; edge_step(); smp_b = '0;
      chk("b_value_cleared", val_b[23:16], 8'd0);

      // ch0 free-run 1000 edges
      en_a[0] = 1'b1;
      repeat (1000) edge_step();
      en_a = '0;
      smp_a[0] = 1'b1; edge_step(); smp_a = '0;
      chk("t1_value", val_a[15:0], 16'd1000);
      chk("t1_match", match_a, 3'b0);
      chk("t1_irq", irq_a, 1'b0);

      // ch1 periodic cmp=9
      wr_a = 1'b1; sel_a = 2'd1; data_a = 16'd9; per_a[1] = 1'b1;
      edge_step();
      wr_a = 1'b0;
      en_a[1] = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         edge_step();
         chk($sformatf("t2_match_edge%0d", k), match_a[1], (k == 10 || k == 20));
      end
      en_a = '0;
      chk("t2_pend_set", pend_a[1], 1'b1);
      chk("t2_irq_set", irq_a, 1'b1);
      ack_a[1] = 1'b1; edge_step(); ack_a = '0;
      chk("t2_pend_acked", pend_a[1], 1'b0);
      chk("t2_irq_lag", irq_a, 1'b1);
      edge_step();
      chk("t2_irq_dropped", irq_a, 1'b0);
      en_a[1] = 1'b1;
      repeat (4) edge_step();
      ack_a[1] = 1'b1; edge_step(); ack_a = '0;
      en_a = '0;
      chk("t2_ack_match_match", match_a[1], 1'b1);
      chk("t2_ack_match_pend", pend_a[1], 1'b1);

      // Table: compare/mode sweep on ch0
      for (int i = 0; i < 5; i++) begin
         clr_a = 3'b001; wr_a = 1'b1; sel_a = 2'd0; data_a = tbl[i].cmp; per_a[0] = tbl[i].per;
         edge_step();
         clr_a = '0; wr_a = 1'b0;
         nm = 0;
         en_a[0] = 1'b1;
         for (int k = 0; k < tbl[i].edges; k++) begin
            edge_step();
            if (match_a[0]) nm++;
         end
         en_a = '0;
         smp_a[0] = 1'b1; edge_step(); smp_a = '0;
         chk($sformatf("tbl%0d_value", i), val_a[15:0], tbl[i].exp_val);
         chk($sformatf("tbl%0d_matches", i), nm, tbl[i].exp_matches);
      end

      // sample + clear same edge, then out-of-range cmp_sel
      clr_a[0] = 1'b1; edge_step(); clr_a = '0;
      en_a[0] = 1'b1;
      repeat (37) edge_step();
      en_a = '0;
      smp_a[0] = 1'b1; clr_a[0] = 1'b1; edge_step(); clr_a = '0;
      chk("t4_sample_preclear", val_a[15:0], 16'd37);
      edge_step(); smp_a = '0;
      chk("t4_cleared", val_a[15:0], 16'd0);
      wr_a = 1'b1; sel_a = 2'd3; data_a = 16'd2; clr_a = 3'b111;
      edge_step();
      wr_a = 1'b0; clr_a = '0;
      en_a = 3'b111;
      nm = 0;
      repeat (5) begin
         edge_step();
         if (match_a != 3'b0) nm++;
      end
      en_a = '0;
      chk("t4_badsel_no_match", nm, 0);

      // reset mid-count with irq pending
      chk("t5_pend_before", pend_a[1], 1'b1);
      en_a = 3'b111;
      repeat (3) edge_step();
      rst_n = 1'b0; edge_step(); rst_n = 1'b1;
      en_a = '0;
      chk("t5_value", val_a, 48'h0);
      chk("t5_match", match_a, 3'b0);
      chk("t5_ovf", ovf_a, 3'b0);
      chk("t5_pend", pend_a, 3'b0);
      chk("t5_irq", irq_a, 1'b0);
      en_a[1] = 1'b1;
      nm = 0;
      repeat (12) begin
         edge_step();
         if (match_a[1]) nm++;
      end
      en_a = '0;
      chk("t5_cmp_allones", nm, 0);

      // prescaler
      clr_a[0] = 1'b1; edge_step(); clr_a = '0;
      presc_div = 16'd4;
      en_a[0] = 1'b1;
      repeat (50) edge_step();
      en_a = '0;
      smp_a[0] = 1'b1; edge_step(); smp_a = '0;
`ifdef TIMER_MC_PRESCALER_EN
      chk("t6_prescaled", val_a[15:0], 16'd10);
`else
      chk("t6_prescaled", val_a[15:0], 16'd50);
`endif
      presc_div = '0;

      // randomized run against the reference model
      rst_n = 1'b0; edge_step(); rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         m_cnt[c] = '0; m_cmp[c] = 16'hffff; m_val[c] = '0;
      end
      m_match = '0; m_ovf = '0; m_pend = '0; m_irq = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (cyc % 300 == 0) per_a = 3'($urandom_range(0, 7));
         for (int c = 0; c < 3; c++) begin
            en_a[c]  = ($urandom_range(0, 4) != 0);
            clr_a[c] = ($urandom_range(0, 19) == 0);
            smp_a[c] = ($urandom_range(0, 3) == 0);
            ack_a[c] = ($urandom_range(0, 5) == 0);
         end
         wr_a   = ($urandom_range(0, 5) == 0);
         sel_a  = 2'($urandom_range(0, 3));
         data_a = 16'($urandom_range(0, 24));

         for (int c = 0; c < 3; c++) begin
            hit = en_a[c] && !clr_a[c] && (m_cnt[c] == m_cmp[c]);
            n_val[c] = smp_a[c] ? m_cnt[c] : m_val[c];
            n_cnt[c] = m_cnt[c];
            n_ovf[c] = m_ovf[c];
            if (clr_a[c]) begin
               n_cnt[c] = 16'd0;
               n_ovf[c] = 1'b0;
            end else if (hit && per_a[c]) begin
               n_cnt[c] = 16'd0;
            end else if (en_a[c]) begin
               n_cnt[c] = 16'((int'(m_cnt[c]) + 1) % 65536);
               if (!per_a[c] && m_cnt[c] == 16'hffff) n_ovf[c] = 1'b1;
            end
            n_match[c] = hit;
            n_pend[c]  = hit | (m_pend[c] & ~ack_a[c]);
         end
         m_irq = (m_pend != 3'b0);
         if (wr_a && int'(sel_a) < 3) m_cmp[sel_a] = data_a;
         for (int c = 0; c < 3; c++) begin
            m_cnt[c] = n_cnt[c];
            m_val[c] = n_val[c];
         end
         m_ovf = n_ovf; m_pend = n_pend; m_match = n_match;

         edge_step();
         chk($sformatf("rnd%0d_value", cyc), val_a, {m_val[2], m_val[1], m_val[0]});
         chk($sformatf("rnd%0d_match", cyc), match_a, m_match);
         chk($sformatf("rnd%0d_ovf", cyc), ovf_a, m_ovf);
         chk($sformatf("rnd%0d_pend", cyc), pend_a, m_pend);
         chk($sformatf("rnd%0d_irq", cyc), irq_a, m_irq);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
